prog_sequencer: RTL and testbench

Program sequencer that sits directly upstream of the BCD adder/accumulator stage and replaces a free-running program counter.
- Generates its own slow execution tick from CLK_50.
- Supports free-run and single-step (debounced pushbutton) modes.
- Fetches 17-bit words from an asynchronous-read ROM, splits each word into {op[16:15], operand[14:0]}, and issues it over a valid/ready handshake.
- Stops on a HALT word or at the end of the program.

---
 rtl/seq_pkg.sv | 18 +
 rtl/btn_debounce.sv | 43 ++++
 rtl/prog_sequencer.sv | 132 +++++++++++++
 tb/tb_prog_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding,
// the HALT sentinel word and the instruction field layout.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED
  } state_t;

  localparam logic [16:0] HALT_WORD = 17'h1FFFF;

  localparam int OP_MSB = 16;
  localparam int OP_LSB = 15;
  localparam int OPND_W = 15;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, level debounce over DEB_CYCLES
// consecutive stable cycles, and a one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TERM) begin
        // Differing for DEB_CYCLES consecutive cycles: accept the new level.
        cnt   <= '0;
        level <= sync[1];
        pulse <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: slow tick or debounced single-step triggers a ROM fetch,
// and the word is issued to the BCD adder stage over a valid/ready handshake.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1,
  parameter int DEB_CYCLES = 500000,
  parameter int ADDR_W     = 4,
  parameter int LAST_ADDR  = 15,
  parameter int WRAP       = 1
) (
  input  logic              CLK_50,
  input  logic              rst_n,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              clr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [16:0]       rom_data,
  output logic [1:0]        instr_op,
  output logic [OPND_W-1:0] instr_operand,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              overrun,
  output logic              tick
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0]   PS_TERM = PS_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LAST_ADDR);

  logic [PS_W-1:0] ps_cnt;
  logic [1:0]      run_sync;
  logic            step_pulse;
  logic            trigger;
  state_t          state;

  always_ff @(posedge CLK_50 or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
      tick   <= 1'b0;
    end else if (ps_cnt == PS_TERM) begin
      ps_cnt <= '0;
      tick   <= 1'b1;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
      tick   <= 1'b0;
    end
  end

  always_ff @(posedge CLK_50 or negedge rst_n) begin
    if (!rst_n) run_sync <= '0;
    else        run_sync <= {run_sync[0], run_sw};
  end

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_deb (
    .clk  (CLK_50),
    .rst_n(rst_n),
    .btn  (step_btn),
    .pulse(step_pulse)
  );

  assign trigger = run_sync[1] ? tick : step_pulse;

  always_ff @(posedge CLK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= '0;
      rom_addr      <= '0;
      instr_op      <= '0;
      instr_operand <= '0;
      instr_valid   <= 1'b0;
      halted        <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      // Triggers are never queued; a busy sequencer only records the loss.
      if (trigger && (state == S_FETCH || state == S_ISSUE)) overrun <= 1'b1;

      if (clr) begin
        pc          <= '0;
        instr_valid <= 1'b0;
        halted      <= 1'b0;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (trigger) begin
              rom_addr <= pc;
              state    <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (rom_data == HALT_WORD) begin
              halted <= 1'b1;
              state  <= S_HALTED;
            end else begin
              instr_op      <= rom_data[OP_MSB:OP_LSB];
              instr_operand <= rom_data[OPND_W-1:0];
              instr_valid   <= 1'b1;
              state         <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (instr_ready) begin
              instr_valid <= 1'b0;
              if (pc == LAST) begin
                if (WRAP != 0) begin
                  pc    <= '0;
                  state <= S_IDLE;
                end else begin
                  halted <= 1'b1;
                  state  <= S_HALTED;
                end
              end else begin
                pc    <= pc + ADDR_W'(1);
                state <= S_IDLE;
              end
            end
          end
          S_HALTED: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: table-driven free-run vectors plus
// directed sequences for backpressure, HALT, step debounce, WRAP=0 and reset.
module tb_prog_sequencer;

  typedef struct {
    logic [1:0]  op;
    logic [14:0] opnd;
  } vec_t;

  vec_t vecs [16];

  logic        clk = 1'b0;
  logic        rst_n, run_sw, step_btn, clr, instr_ready;
  logic [16:0] rom [16];
  logic [3:0]  rom_addr, pc;
  logic [16:0] rom_data;
  logic [1:0]  instr_op;
  logic [14:0] instr_operand;
  logic        instr_valid, halted, overrun, tick;

  logic        run_sw_h, step_btn_h, clr_h, ready_h;
  logic [16:0] rom_h [16];
  logic [3:0]  rom_addr_h, pc_h;
  logic [16:0] rom_data_h;
  logic [1:0]  op_h;
  logic [14:0] opnd_h;
  logic        valid_h, halted_h, overrun_h, tick_h;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_data   = rom[rom_addr];
  assign rom_data_h = rom_h[rom_addr_h];

  prog_sequencer #(
    .CLK_HZ(10), .TICK_HZ(1), .DEB_CYCLES(4), .ADDR_W(4), .LAST_ADDR(15), .WRAP(1)
  ) dut (
    .CLK_50(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn), .clr(clr),
    .rom_addr(rom_addr), .rom_data(rom_data), .instr_op(instr_op),
    .instr_operand(instr_operand), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .halted(halted), .overrun(overrun),
    .tick(tick)
  );

  prog_sequencer #(
    .CLK_HZ(10), .TICK_HZ(1), .DEB_CYCLES(4), .ADDR_W(4), .LAST_ADDR(15), .WRAP(0)
  ) dut_h (
    .CLK_50(clk), .rst_n(rst_n), .run_sw(run_sw_h), .step_btn(step_btn_h), .clr(clr_h),
    .rom_addr(rom_addr_h), .rom_data(rom_data_h), .instr_op(op_h),
    .instr_operand(opnd_h), .instr_valid(valid_h),
    .instr_ready(ready_h), .pc(pc_h), .halted(halted_h), .overrun(overrun_h),
    .tick(tick_h)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tick) return;
    end
    check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    int  last_tick;
    int  n_valid;
    bit  ok;
    logic [14:0] cap;

    vecs = '{
      '{2'd0, 15'h0000}, '{2'd1, 15'h0001}, '{2'd2, 15'h0002}, '{2'd3, 15'h0003},
      '{2'd0, 15'h0004}, '{2'd1, 15'h0005}, '{2'd2, 15'h7FFF}, '{2'd3, 15'h5555},
      '{2'd0, 15'h2AAA}, '{2'd1, 15'h0009}, '{2'd2, 15'h000A}, '{2'd3, 15'h7FFE},
      '{2'd0, 15'h000C}, '{2'd1, 15'h000D}, '{2'd2, 15'h000E}, '{2'd3, 15'h000F}
    };
    for (int k = 0; k < 16; k++) begin
      rom[k]   = {vecs[k].op, vecs[k].opnd};
      rom_h[k] = {2'b00, 15'(k)};
    end

    rst_n = 1'b0; run_sw = 1'b1; step_btn = 1'b0; clr = 1'b0; instr_ready = 1'b1;
    run_sw_h = 1'b0; step_btn_h = 1'b0; clr_h = 1'b0; ready_h = 1'b1;
    last_tick = 0;
    step(3);
    check("rst_pc", pc, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tick", tick, 0);
    check("rst_op", instr_op, 0);
    check("rst_operand", instr_operand, 0);
    rst_n = 1'b1;

    // Free run, ready high: one issue two cycles after every tick, pc wraps.
    for (int k = 0; k < 17; k++) begin
      wait_tick();
      if (k > 0) check("tick_period", cyc - last_tick, 10);
      last_tick = cyc;
      step();
      check("run_fetch_gap", instr_valid, 0);
      step();
      check("run_valid", instr_valid, 1);
      check("run_op", instr_op, vecs[k % 16].op);
      check("run_operand", instr_operand, vecs[k % 16].opnd);
      check("run_pc_at_issue", pc, k % 16);
      step();
      check("run_valid_drop", instr_valid, 0);
      check("run_pc_next", pc, (k + 1) % 16);
    end
    check("run_no_overrun", overrun, 0);

    // Backpressure: payload and pc frozen, two ticks dropped.
    pulse_clr();
    check("clr_idle_pc", pc, 0);
    instr_ready = 1'b0;
    wait_tick();
    step(2);
    check("bp_valid", instr_valid, 1);
    check("bp_operand", instr_operand, vecs[0].opnd);
    ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (instr_valid !== 1'b1 || instr_operand !== vecs[0].opnd ||
          instr_op !== vecs[0].op || pc !== 4'd0) ok = 1'b0;
    end
    check("bp_hold_stable", ok, 1);
    check("bp_overrun", overrun, 1);
    instr_ready = 1'b1;
    step();
    check("bp_release_valid", instr_valid, 0);
    check("bp_release_pc", pc, 1);
    wait_tick();
    step(2);
    check("bp_next_operand", instr_operand, vecs[1].opnd);
    step();
    check("bp_next_pc", pc, 2);

    // HALT word at address 5.
    pulse_clr();
    rom[5] = 17'h1FFFF;
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      step(2);
      check("halt_pre_operand", instr_operand, vecs[k].opnd);
    end
    wait_tick();
    step(2);
    check("halt_flag", halted, 1);
    check("halt_valid", instr_valid, 0);
    check("halt_pc", pc, 5);
    n_valid = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (instr_valid) n_valid++;
    end
    check("halt_no_issue", n_valid, 0);
    check("halt_sticky", halted, 1);
    rom[5] = {vecs[5].op, vecs[5].opnd};
    pulse_clr();
    check("halt_clr_flag", halted, 0);
    check("halt_clr_pc", pc, 0);
    instr_ready = 1'b0;
    wait_tick();
    step(2);
    check("halt_resume_operand", instr_operand, vecs[0].opnd);
    check("halt_resume_valid", instr_valid, 1);
    // clr wins over a simultaneous handshake.
    clr = 1'b1;
    instr_ready = 1'b1;
    step();
    clr = 1'b0;
    check("clr_prio_valid", instr_valid, 0);
    check("clr_prio_pc", pc, 0);
    check("overrun_sticky", overrun, 1);

    // Step mode: ticks ignored, short press rejected, bounced press issues once.
    run_sw = 1'b0;
    n_valid = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (instr_valid) n_valid++;
    end
    check("step_ticks_ignored", n_valid, 0);
    step_btn = 1'b1;
    step(3);
    step_btn = 1'b0;
    n_valid = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (instr_valid) n_valid++;
    end
    check("step_short_press", n_valid, 0);
    step_btn = 1'b1; step();
    step_btn = 1'b0; step();
    step_btn = 1'b1;
    n_valid = 0;
    cap = '0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (i == 10) step_btn = 1'b0;
      if (instr_valid) begin
        n_valid++;
        cap = instr_operand;
      end
    end
    check("step_one_issue", n_valid, 1);
    check("step_operand", cap, vecs[0].opnd);
    check("step_pc", pc, 1);

    // WRAP=0 instance: runs the program once and halts at LAST_ADDR.
    run_sw_h = 1'b1;
    n_valid = 0;
    cap = '0;
    for (int i = 0; i < 250; i++) begin
      step();
      if (valid_h) begin
        n_valid++;
        cap = opnd_h;
      end
      if (halted_h) break;
    end
    check("nowrap_issues", n_valid, 16);
    check("nowrap_last_operand", cap, 15);
    check("nowrap_halted", halted_h, 1);
    check("nowrap_pc", pc_h, 15);
    n_valid = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (valid_h) n_valid++;
    end
    check("nowrap_silent", n_valid, 0);

    // Async reset in ISSUE clears outputs before the next edge.
    run_sw = 1'b1;
    instr_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("areset_reach_issue", ok, 1);
    check("areset_pre_pc", pc, 1);
    check("areset_pre_overrun", overrun, 1);
    rst_n = 1'b0;
    #1;
    check("areset_valid", instr_valid, 0);
    check("areset_pc", pc, 0);
    check("areset_overrun", overrun, 0);
    check("areset_halted", halted, 0);
    check("areset_halted_h", halted_h, 0);
    step();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    wait_tick();
    step(2);
    check("areset_resume_valid", instr_valid, 1);
    check("areset_resume_operand", instr_operand, vecs[0].opnd);
    check("areset_resume_pc", pc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
